// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared types and helpers for the reset sequencer: the
//               sequencer state encoding, a clog2-style width helper and the
//               width of the lock-loss event counter.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

  // Width of the saturating lock-loss event counter.
  localparam int LOCK_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // Smallest w >= 1 such that 2**w >= n, i.e. clog2(n) clamped to 1 bit.
  function automatic int width_for(input int n);
    int w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) begin
      w = w + 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage : reset_seq_pkg
`default_nettype wire

// File: rtl/reset_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_if
// Description : Signal bundle between the arcade top level and the reset
//               sequencer.
//                 dcm_locked     - DCM lock, asynchronous to sysclk
//                 button         - raw reset button, active-high, bouncy
//                 rst[NCH]       - per-channel reset, active-high
//                 ready          - all channels released
//                 lock_loss_cnt  - saturating lock-loss event count
//               master: the surrounding logic (drives lock/button)
//               slave : the sequencer (drives resets/status)
// Revision    : 1.0 - initial release
// ============================================================================
interface reset_seq_if #(
  parameter int NCH = 2
);
  import reset_seq_pkg::*;

  logic                  dcm_locked;
  logic                  button;
  logic [NCH-1:0]        rst;
  logic                  ready;
  logic [LOCK_CNT_W-1:0] lock_loss_cnt;

  modport master (
    output dcm_locked,
    output button,
    input  rst,
    input  ready,
    input  lock_loss_cnt
  );

  modport slave (
    input  dcm_locked,
    input  button,
    output rst,
    output ready,
    output lock_loss_cnt
  );

endinterface : reset_seq_if
`default_nettype wire

// File: rtl/reset_seq_debounce.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_debounce
// Description : Reset-button conditioning. Two-flop synchroniser followed by
//               a level debouncer: btn_db follows the synchronised button only
//               after it has disagreed for DEB_CYCLES consecutive cycles.
// Ports       : sysclk  - system clock
//               reset_n - asynchronous active-low reset
//               button  - raw asynchronous button input
//               btn_db  - debounced, synchronised button level
// Revision    : 1.0 - initial release
// ============================================================================
module reset_seq_debounce #(
  parameter int DEB_CYCLES = 65535,
  parameter int CNT_W      = 16
) (
  input  wire logic sysclk,
  input  wire logic reset_n,
  input  wire logic button,
  output logic      btn_db
);

  logic             button_meta;
  logic             button_s;
  logic [CNT_W-1:0] deb_cnt;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      button_meta <= 1'b0;
      button_s    <= 1'b0;
      btn_db      <= 1'b0;
      deb_cnt     <= '0;
    end else begin
      button_meta <= button;
      button_s    <= button_meta;
      // Any cycle where the input agrees with the debounced level restarts
      // the qualification window.
      if (button_s != btn_db) begin
        if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          btn_db  <= button_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

endmodule : reset_seq_debounce
`default_nettype wire

// File: rtl/reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq
// Description : Power-on / run-time reset sequencer. Waits for DCM lock plus
//               HOLD_CYCLES, then releases NCH reset channels from bit 0
//               upward, STAGE_CYCLES apart. Lock loss (or a debounced button
//               press) drops every channel back into reset. Lock-loss events
//               are counted (saturating) for debug.
// Ports       : sysclk  - system clock, all logic on posedge
//               reset_n - asynchronous active-low reset
//               bus     - reset_seq_if slave (dcm_locked, button in;
//                         rst, ready, lock_loss_cnt out)
// Options     : RESET_SEQ_BUTTON_EN - when defined, the button is
//               synchronised, debounced and included in the abort condition;
//               otherwise the button input is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NCH          = 2,
  parameter int HOLD_CYCLES  = 255,
  parameter int STAGE_CYCLES = 16,
  parameter int DEB_CYCLES   = 65535
) (
  input  wire logic  sysclk,
  input  wire logic  reset_n,
  reset_seq_if.slave bus
);

  localparam int CNT_W   = width_for(max3(HOLD_CYCLES, STAGE_CYCLES, DEB_CYCLES) + 1);
  localparam int STAGE_W = width_for(NCH + 1);

  // --------------------------------------------------------------------------
  // Lock synchroniser and lock-loss counter
  // --------------------------------------------------------------------------
  logic                  locked_meta;
  logic                  locked_s;
  logic [LOCK_CNT_W-1:0] lock_loss_cnt;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      locked_meta   <= 1'b0;
      locked_s      <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      locked_meta <= bus.dcm_locked;
      locked_s    <= locked_meta;
      // locked_meta is the value locked_s takes on this edge, so this counts
      // the 1->0 transition of locked_s on the edge it happens.
      if (locked_s && !locked_meta && (lock_loss_cnt != {LOCK_CNT_W{1'b1}})) begin
        lock_loss_cnt <= lock_loss_cnt + LOCK_CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Abort condition
  // --------------------------------------------------------------------------
  logic abort;

`ifdef RESET_SEQ_BUTTON_EN
  logic btn_db;

  reset_seq_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_debounce (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .button  (bus.button),
    .btn_db  (btn_db)
  );

  assign abort = !locked_s || btn_db;
`else
  wire unused_button = bus.button;

  assign abort = !locked_s;
`endif

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [NCH-1:0]     rst_q, rst_d;
  logic               ready_q, ready_d;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  // Released channels always form a contiguous run from bit 0, so releasing
  // the next channel is a left shift that brings a 0 into bit 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    ready_d = ready_q;

    if (abort) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      stage_d = '0;
      rst_d   = '1;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            rst_d = rst_q << 1;
            cnt_d = '0;
            if (NCH == 1) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              stage_d = STAGE_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt_q == CNT_W'(STAGE_CYCLES - 1)) begin
            rst_d   = rst_q << 1;
            cnt_d   = '0;
            stage_d = stage_q + STAGE_W'(1);
            if (stage_q == STAGE_W'(NCH - 1)) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RUN: begin
          // Holds until an abort.
        end

        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          stage_d = '0;
          rst_d   = '1;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.rst           = rst_q;
  assign bus.ready         = ready_q;
  assign bus.lock_loss_cnt = lock_loss_cnt;

endmodule : reset_seq
`default_nettype wire

// File: tb/tb_reset_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_reset_seq
// Description : Self-checking bench for reset_seq. Two instances share the
//               stimulus: A (NCH=3, HOLD=8, STAGE=4, DEB=5) and
//               B (NCH=1, HOLD=1, STAGE=4, DEB=5). A reference model derives
//               the expected outputs from the number of consecutive
//               non-abort cycles; expectations are queued per edge and a
//               monitor compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_seq;

  localparam int NCH_A = 3, HOLD_A = 8, STAGE_A = 4;
  localparam int NCH_B = 1, HOLD_B = 1, STAGE_B = 4;
  localparam int DEB   = 5;
`ifdef RESET_SEQ_BUTTON_EN
  localparam bit BTN_EN = 1'b1;
`else
  localparam bit BTN_EN = 1'b0;
`endif

  logic sysclk     = 1'b0;
  logic reset_n    = 1'b0;
  logic dcm_locked = 1'b0;
  logic button     = 1'b0;

  reset_seq_if #(.NCH(NCH_A)) bus_a ();
  reset_seq_if #(.NCH(NCH_B)) bus_b ();

  assign bus_a.dcm_locked = dcm_locked;
  assign bus_a.button     = button;
  assign bus_b.dcm_locked = dcm_locked;
  assign bus_b.button     = button;

  reset_seq #(.NCH(NCH_A), .HOLD_CYCLES(HOLD_A), .STAGE_CYCLES(STAGE_A), .DEB_CYCLES(DEB))
    dut_a (.sysclk(sysclk), .reset_n(reset_n), .bus(bus_a));
  reset_seq #(.NCH(NCH_B), .HOLD_CYCLES(HOLD_B), .STAGE_CYCLES(STAGE_B), .DEB_CYCLES(DEB))
    dut_b (.sysclk(sysclk), .reset_n(reset_n), .bus(bus_b));

  always #5 sysclk = ~sysclk;

  typedef struct packed {
    logic [7:0] cnt;
    logic       ready;
    logic [2:0] rst;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  bit s1, ls, b1, bs, db;
  int mism, lcnt, k_a, k_b;

  // Channels released after k consecutive non-abort cycles.
  function automatic int released(input int nch, input int hold, input int stage, input int k);
    int r;
    if (k < hold) r = 0;
    else          r = 1 + (k - hold) / stage;
    if (r > nch) r = nch;
    return r;
  endfunction

  function automatic exp_t expect_of(input int nch, input int hold, input int stage, input int k);
    exp_t e;
    int   r;
    r       = released(nch, hold, stage, k);
    e.rst   = 3'(((1 << nch) - 1) & ~((1 << r) - 1));
    e.ready = (r == nch);
    e.cnt   = 8'(lcnt);
    return e;
  endfunction

  task automatic model_edge();
    bit abort;
    if (!reset_n) begin
      s1 = 0; ls = 0; b1 = 0; bs = 0; db = 0;
      mism = 0; lcnt = 0; k_a = 0; k_b = 0;
    end else begin
      abort = !ls || (BTN_EN && db);
      k_a = abort ? 0 : ((k_a < 1000000) ? k_a + 1 : k_a);
      k_b = abort ? 0 : ((k_b < 1000000) ? k_b + 1 : k_b);
      if (BTN_EN) begin
        if (bs != db) begin
          mism++;
          if (mism == DEB) begin
            db   = !db;
            mism = 0;
          end
        end else begin
          mism = 0;
        end
      end
      if (ls && !s1 && lcnt < 255) lcnt++;
      ls = s1; s1 = dcm_locked;
      bs = b1; b1 = button;
    end
    q_a.push_back(expect_of(NCH_A, HOLD_A, STAGE_A, k_a));
    q_b.push_back(expect_of(NCH_B, HOLD_B, STAGE_B, k_b));
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_rst",   int'(bus_a.rst),           int'(e.rst));
        check("a_ready", int'(bus_a.ready),         int'(e.ready));
        check("a_lcnt",  int'(bus_a.lock_loss_cnt), int'(e.cnt));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_rst",   int'(bus_b.rst),           int'(e.rst));
        check("b_ready", int'(bus_b.ready),         int'(e.ready));
        check("b_lcnt",  int'(bus_b.lock_loss_cnt), int'(e.cnt));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic cyc(input bit rn, input bit l, input bit b);
    @(negedge sysclk);
    #1;
    reset_n    = rn;
    dcm_locked = l;
    button     = b;
    if (!rn) begin
      #1;
      check("async_rst_a",   int'(bus_a.rst),           7);
      check("async_ready_a", int'(bus_a.ready),         0);
      check("async_lcnt_a",  int'(bus_a.lock_loss_cnt), 0);
      check("async_rst_b",   int'(bus_b.rst),           1);
    end
    @(posedge sysclk);
    cycle++;
    model_edge();
  endtask

  task automatic run_locked(input int n, input bit b);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, b);
  endtask

  initial begin
    bit btn_lvl;
    bit rn;

    // Reset, then lock held: full release sequence.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    run_locked(25, 1'b0);
    #1;
    check("run_rst_a",   int'(bus_a.rst),   0);
    check("run_ready_a", int'(bus_a.ready), 1);

    // One-cycle lock drop from RUN.
    cyc(1'b1, 1'b0, 1'b0);
    run_locked(25, 1'b0);
    #1;
    check("lcnt_after_drop", int'(bus_a.lock_loss_cnt), 1);

    // Short button pulses, too short to debounce.
    for (int p = 0; p < 4; p++) begin
      run_locked(4, 1'b1);
      run_locked(6, 1'b0);
    end

    // Button pressed while channels are releasing.
    cyc(1'b1, 1'b0, 1'b0);
    run_locked(12, 1'b0);
    run_locked(6, 1'b1);
    run_locked(30, 1'b0);

    // Button held for a long time in RUN.
    run_locked(100, 1'b1);
    run_locked(40, 1'b0);

    // Many lock drops: counter saturates.
    for (int t = 0; t < 300; t++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
    end
    run_locked(4, 1'b0);
    #1;
    check("lcnt_saturated", int'(bus_a.lock_loss_cnt), 255);

    // reset_n asserted mid-sequence, then a fresh start.
    run_locked(6, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    run_locked(10, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    run_locked(25, 1'b0);

    // Randomised lock, button and occasional reset_n.
    btn_lvl = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 8) btn_lvl = ~btn_lvl;
      rn = ($urandom_range(0, 999) >= 5);
      cyc(rn, ($urandom_range(0, 99) < 96), btn_lvl);
    end
    run_locked(30, 1'b0);

    @(negedge sysclk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reset_seq
`default_nettype wire
